// File: rtl/div_ctrl.sv
// div_ctrl: sequencing stage between EX and an iterative divider.
// It accepts DIV/DIVU from EX, latches and holds the operands, and drives the
// divider's level start. It stalls the pipeline while the divider runs, then
// captures quotient/remainder and issues one HI/LO write. Divide-by-zero,
// flush and a watchdog abort are also handled here.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   div_op, div_signed           DIV/DIVU request from EX (held while stalled)
//   op_a, op_b                   dividend / divisor from EX
//   flush                        kill the in-flight divide (no HI/LO write)
//   div_done                     one-cycle done pulse from the divider
//   div_quotient, div_remainder  divider results
//   div_start                    level start to the divider
//   div_sign, div_a, div_b       latched operands, held stable for the divider
//   stall_req                    freeze IF/ID/EX
//   hilo_we                      one-cycle HI/LO write strobe
//   hi_wdata, lo_wdata           remainder / quotient to HI / LO
//   timeout_err                  sticky watchdog-abort flag, cleared by rst
module div_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_op,
    input  logic        div_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        div_start,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WB
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WD_W-1:0] wdog;
    logic            accept;
    logic            div_by_zero;
    logic            capture;
    logic            abort;
    logic            wd_expire;

    assign accept      = (state == IDLE) && div_op && !flush;
    assign div_by_zero = (op_b == 32'd0);
    // The counter holds the number of BUSY cycles already completed, so this
    // fires during the TIMEOUT-th BUSY cycle.
    assign wd_expire   = (wdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        next_state = state;
        div_start  = 1'b0;
        stall_req  = 1'b0;
        hilo_we    = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                stall_req = div_op && !flush;
                if (accept) begin
                    next_state = div_by_zero ? WB : BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                // Start drops combinationally in the done cycle so the
                // divider never runs an extra iteration.
                div_start = !div_done && !flush;
                if (flush) begin
                    next_state = IDLE;
                end else if (div_done) begin
                    capture    = 1'b1;
                    next_state = WB;
                end else if (wd_expire) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            WB: begin
                hilo_we    = !flush;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            div_sign    <= 1'b0;
            div_a       <= 32'd0;
            div_b       <= 32'd0;
            hi_wdata    <= 32'd0;
            lo_wdata    <= 32'd0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                div_a    <= op_a;
                div_b    <= op_b;
                div_sign <= div_signed;
                wdog     <= '0;
                // Divide-by-zero bypasses the divider with fixed results.
                if (div_by_zero) begin
                    lo_wdata <= 32'hFFFF_FFFF;
                    hi_wdata <= op_a;
                end
            end
            if (state == BUSY) begin
                wdog <= wdog + WD_W'(1);
            end
            if (capture) begin
                lo_wdata <= div_quotient;
                hi_wdata <= div_remainder;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing stage between the EX stage and the iterative divider. Accepts DIV/DIVU requests from EX, latches and holds the operands, and drives the divider's level-sensitive start. It stalls the pipeline while the divider runs, captures quotient/remainder on the divider's done pulse, and issues one HI/LO write. It also handles divide-by-zero, pipeline flush and a watchdog timeout.

## Interface
Parameters:
- TIMEOUT, 40, cycles in BUSY without div_done before abort (must be > 34)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- div_op  in  1  EX holds a DIV/DIVU this cycle; held by EX while stall_req=1
- div_signed  in  1  1=DIV (signed), 0=DIVU
- op_a  in  32  dividend (rs)
- op_b  in  32  divisor (rt)
- flush  in  1  exception/flush from CP0; kills the in-flight divide
- div_done  in  1  single-cycle done pulse from the divider
- div_quotient  in  32  divider quotient
- div_remainder  in  32  divider remainder
- div_start  out  1  level start to the divider
- div_sign  out  1  latched signed flag to the divider
- div_a  out  32  latched dividend to the divider
- div_b  out  32  latched divisor to the divider
- stall_req  out  1  freeze IF/ID/EX
- hilo_we  out  1  one-cycle write strobe for HI and LO
- hi_wdata  out  32  remainder
- lo_wdata  out  32  quotient
- timeout_err  out  1  sticky; set on watchdog abort, cleared by rst only

## Operation
- States: IDLE, BUSY, WB.
- IDLE:
  - On div_op=1 and flush=0, latch op_a/op_b/div_signed into div_a/div_b/div_sign.
  - If op_b==0, go to WB with lo=32'hFFFFFFFF and hi=op_a; the divider is never started.
  - Otherwise clear the watchdog counter and go to BUSY.
- BUSY:
  - div_start = 1 while state==BUSY && !div_done && !flush. This is combinational, so start is already low at the edge that ends the done cycle. The divider therefore performs no extra iteration.
  - On div_done: register div_quotient into lo and div_remainder into hi, then go to WB.
  - Operands stay stable through the done cycle, because the divider's sign fix-up reads them live.
- WB: hilo_we=1 for exactly one cycle, hi_wdata/lo_wdata valid, then go to IDLE.
- flush in BUSY or WB: go to IDLE, no HI/LO write, div_start low that same cycle. flush in WB suppresses hilo_we.
- flush with div_op in IDLE: no acceptance.
- Watchdog: counter increments each BUSY cycle. Reaching TIMEOUT sets timeout_err, drops start and returns to IDLE with no write.
- stall_req = (IDLE && div_op && !flush) || BUSY. It is low in WB, so EX advances on the write cycle.
- Latched operands and hi/lo hold their value in IDLE; they are updated only on acceptance or capture.
- Reset values: state IDLE; div_start, div_sign, stall_req, hilo_we, timeout_err = 0; div_a, div_b, hi_wdata, lo_wdata = 0; watchdog = 0.
- rst mid-divide: return to IDLE with all outputs at reset values. div_start falls in the next cycle, so the divider counter clears.

## Timing
- T0: IDLE with div_op=1 and op_b≠0. stall_req=1 (combinational), operands latched at the T0 edge.
- T1: BUSY, div_start=1. This is the divider load cycle.
- T2..T33: 32 iteration cycles.
- T34: div_done=1, div_start=0, capture at the T34 edge, stall_req=1.
- T35: WB, hilo_we=1, stall_req=0.
- T36: IDLE. A new div_op can be accepted here, and div_start rises at T37. The divider always sees start low for at least one cycle between operations.
- Divide-by-zero: T0 accept, T1 hilo_we=1, stall_req high only in T0.
- Back-to-back: a second div_op can be held by EX in T35. It is not accepted until T36, because stall_req is low in WB and EX advances.

## Test plan
- DIVU 100/7, no flush → div_done at T34, hilo_we at T35 with lo=14, hi=2; stall_req high T0..T34 only.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- DIV 5/0 → div_start never asserts, hilo_we at T1 with lo=0xFFFFFFFF, hi=5.
- DIVU 100/7 with flush at T10 → div_start low at T10, IDLE at T11, no hilo_we. A new DIVU 9/3 accepted at T11 gives lo=3, hi=0 with correct latency.
- Divider model never asserts div_done → abort after TIMEOUT BUSY cycles: timeout_err=1, stall_req=0, no hilo_we. timeout_err stays 1 until rst.
- rst asserted at T20 of a divide → all outputs 0 next cycle. A DIVU 20/6 issued afterwards returns lo=3, hi=2.
